// File: rtl/l15_simple_transducer.sv
// Core-to-L1.5 transducer: one outstanding load/store, IDLE->REQ->WAIT->RESP.
// Optional response timeout: define L15_TRANSDUCER_TIMEOUT_EN.
module l15_simple_transducer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_val,
  output logic        core_req_rdy,
  input  logic        core_req_rw,
  input  logic [39:0] core_req_addr,
  input  logic [2:0]  core_req_size,
  input  logic        core_req_nc,
  input  logic [63:0] core_req_wdata,
  output logic        core_resp_val,
  input  logic        core_resp_rdy,
  output logic [63:0] core_resp_rdata,
  output logic [1:0]  core_resp_err,
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic        transducer_l15_nc,
  output logic [2:0]  transducer_l15_size,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic [63:0] transducer_l15_data_next_entry,
  output logic        transducer_l15_threadid,
  output logic [3:0]  transducer_l15_amo_op,
  output logic        transducer_l15_prefetch,
  output logic        transducer_l15_invalidate_cacheline,
  output logic        transducer_l15_blockstore,
  output logic        transducer_l15_blockinitstore,
  output logic [1:0]  transducer_l15_l1rplway,
  output logic [32:0] transducer_l15_csm_data,
  output logic        transducer_l15_req_ack,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [1:0]  l15_transducer_error,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP
  } state_e;

  state_e state_q, state_d;

  logic        rw_q, rw_d;
  logic [39:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        nc_q, nc_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic       accept;
  logic       busy;
  logic [3:0] exp_rt;
  logic       rsp_hit;
  logic       take;
  logic       to_fire;

  assign accept  = core_req_val && (state_q == S_IDLE);
  assign busy    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign exp_rt  = rw_q ? 4'b0100 : 4'b0000;
  assign rsp_hit = l15_transducer_val
                && (l15_transducer_returntype == exp_rt);
  // A hit in REQ only counts once the request itself is acked
  assign take = rsp_hit
             && ((state_q == S_WAIT)
             || ((state_q == S_REQ) && l15_transducer_ack));

`ifdef L15_TRANSDUCER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Cycles spent in REQ/WAIT, cleared on acceptance, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if (busy && (cnt_q != CW'(TIMEOUT_CYCLES)))
      cnt_d = cnt_q + CW'(1);
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign to_fire = busy
                && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_to;
  assign unused_to = 32'(TIMEOUT_CYCLES);
  assign to_fire   = 1'b0;
`endif

  logic unused_hdr;
  assign unused_hdr = l15_transducer_header_ack;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (core_req_val) state_d = S_REQ;
      S_REQ: begin
        if (take || to_fire)         state_d = S_RESP;
        else if (l15_transducer_ack) state_d = S_WAIT;
      end
      S_WAIT: if (take || to_fire) state_d = S_RESP;
      S_RESP: if (core_resp_rdy)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and response capture
  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    size_d  = size_q;
    nc_d    = nc_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      rw_d    = core_req_rw;
      addr_d  = core_req_addr;
      size_d  = core_req_size;
      nc_d    = core_req_nc;
      wdata_d = core_req_wdata;
    end
    if (take) begin
      if (rw_q)           rdata_d = '0;
      else if (addr_q[3]) rdata_d = l15_transducer_data_1;
      else                rdata_d = l15_transducer_data_0;
      err_d = {1'b0, l15_transducer_error};
    end else if (to_fire) begin
      rdata_d = '0;
      err_d   = 2'b10;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      nc_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      nc_q    <= nc_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state and held registers
  always_comb begin
    core_req_rdy           = (state_q == S_IDLE);
    transducer_l15_val     = (state_q == S_REQ);
    core_resp_val          = (state_q == S_RESP);
    core_resp_rdata        = rdata_q;
    core_resp_err          = err_q;
    transducer_l15_rqtype  = {4'b0000, rw_q};
    transducer_l15_nc      = nc_q;
    transducer_l15_size    = size_q;
    transducer_l15_address = addr_q;
    transducer_l15_data    = wdata_q;
    transducer_l15_req_ack = l15_transducer_val;
  end

  assign transducer_l15_data_next_entry      = '0;
  assign transducer_l15_threadid             = 1'b0;
  assign transducer_l15_amo_op               = '0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = '0;
  assign transducer_l15_csm_data             = '0;

endmodule

// File: tb/tb_l15_simple_transducer.sv
// Scoreboard bench for l15_simple_transducer.
// Directed transactions; monitor pops expected responses on handshake.
module tb_l15_simple_transducer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_val;
  logic        core_req_rdy;
  logic        core_req_rw;
  logic [39:0] core_req_addr;
  logic [2:0]  core_req_size;
  logic        core_req_nc;
  logic [63:0] core_req_wdata;
  logic        core_resp_val;
  logic        core_resp_rdy;
  logic [63:0] core_resp_rdata;
  logic [1:0]  core_resp_err;
  logic        t_val;
  logic [4:0]  t_rqtype;
  logic        t_nc;
  logic [2:0]  t_size;
  logic [39:0] t_address;
  logic [63:0] t_data;
  logic [63:0] t_data_next;
  logic        t_threadid;
  logic [3:0]  t_amo_op;
  logic        t_prefetch;
  logic        t_inv;
  logic        t_bs;
  logic        t_bis;
  logic [1:0]  t_rplway;
  logic [32:0] t_csm;
  logic        t_req_ack;
  logic        l_ack;
  logic        l_hack;
  logic        l_val;
  logic [3:0]  l_rt;
  logic [1:0]  l_err;
  logic [63:0] l_d0;
  logic [63:0] l_d1;

  always #5 clk = ~clk;

  l15_simple_transducer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_req_val(core_req_val),
    .core_req_rdy(core_req_rdy),
    .core_req_rw(core_req_rw),
    .core_req_addr(core_req_addr),
    .core_req_size(core_req_size),
    .core_req_nc(core_req_nc),
    .core_req_wdata(core_req_wdata),
    .core_resp_val(core_resp_val),
    .core_resp_rdy(core_resp_rdy),
    .core_resp_rdata(core_resp_rdata),
    .core_resp_err(core_resp_err),
    .transducer_l15_val(t_val),
    .transducer_l15_rqtype(t_rqtype),
    .transducer_l15_nc(t_nc),
    .transducer_l15_size(t_size),
    .transducer_l15_address(t_address),
    .transducer_l15_data(t_data),
    .transducer_l15_data_next_entry(t_data_next),
    .transducer_l15_threadid(t_threadid),
    .transducer_l15_amo_op(t_amo_op),
    .transducer_l15_prefetch(t_prefetch),
    .transducer_l15_invalidate_cacheline(t_inv),
    .transducer_l15_blockstore(t_bs),
    .transducer_l15_blockinitstore(t_bis),
    .transducer_l15_l1rplway(t_rplway),
    .transducer_l15_csm_data(t_csm),
    .transducer_l15_req_ack(t_req_ack),
    .l15_transducer_ack(l_ack),
    .l15_transducer_header_ack(l_hack),
    .l15_transducer_val(l_val),
    .l15_transducer_returntype(l_rt),
    .l15_transducer_error(l_err),
    .l15_transducer_data_0(l_d0),
    .l15_transducer_data_1(l_d1)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  e;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   nresp  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n && core_resp_val && core_resp_rdy) begin
      nresp++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=%h required=none",
                 core_resp_rdata);
      end else begin
        x = sbq.pop_front();
        chk("resp_rdata", core_resp_rdata, x.d);
        chk("resp_err", 64'(core_resp_err), 64'(x.e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw,
                       input logic [39:0] a,
                       input logic [63:0] wd);
    chk("req_rdy_idle", 64'(core_req_rdy), 64'd1);
    core_req_val   = 1'b1;
    core_req_rw    = rw;
    core_req_addr  = a;
    core_req_size  = 3'b011;
    core_req_nc    = 1'b1;
    core_req_wdata = wd;
    cyc();
    core_req_val   = 1'b0;
    core_req_addr  = '1;
    core_req_wdata = '1;
  endtask

  task automatic ack_now();
    l_ack = 1'b1;
    cyc();
    l_ack = 1'b0;
  endtask

  task automatic respond(input logic [3:0] rt,
                         input logic [63:0] d0,
                         input logic [63:0] d1,
                         input logic [1:0] er);
    l_val = 1'b1;
    l_rt  = rt;
    l_d0  = d0;
    l_d1  = d1;
    l_err = er;
    @(negedge clk);
    chk("req_ack_hi", 64'(t_req_ack), 64'd1);
    cyc();
    l_val = 1'b0;
    l_rt  = 4'hF;
  endtask

  initial begin : wd
    #200000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    core_req_val = 1'b0;
    core_req_rw = 1'b0;
    core_req_addr = '0;
    core_req_size = '0;
    core_req_nc = 1'b0;
    core_req_wdata = '0;
    core_resp_rdy = 1'b1;
    l_ack = 1'b0;
    l_hack = 1'b0;
    l_val = 1'b0;
    l_rt = 4'hF;
    l_err = '0;
    l_d0 = '0;
    l_d1 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_l15_val", 64'(t_val), 64'd0);
    chk("rst_resp_val", 64'(core_resp_val), 64'd0);
    chk("rst_rdata", core_resp_rdata, 64'd0);
    chk("rst_err", 64'(core_resp_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'(core_req_rdy), 64'd1);
    cyc();

    // load, ack after 3 cycles, data_1 selected by addr[3]
    sbq.push_back('{64'hDEAD_BEEF_0000_0001, 2'b00});
    issue(1'b0, 40'h00_8000_0008, 64'h0);
    @(negedge clk);
    chk("ld_l15_val", 64'(t_val), 64'd1);
    chk("ld_rqtype", 64'(t_rqtype), 64'd0);
    chk("ld_addr", 64'(t_address), 64'h00_8000_0008);
    chk("ld_size", 64'(t_size), 64'd3);
    chk("tie_off", {t_data_next[31:0], t_csm[31:0]}, 64'd0);
    cyc();
    @(negedge clk);
    chk("ld_addr_hold", 64'(t_address), 64'h00_8000_0008);
    cyc();
    ack_now();
    @(negedge clk);
    chk("ld_wait_val", 64'(t_val), 64'd0);
    respond(4'b0000, 64'h1111, 64'hDEAD_BEEF_0000_0001, 2'b00);
    cyc();
    chk("ld_nresp", 64'(nresp), 64'd1);

    // store, ack with first val cycle, ST_ACK 5 cycles later
    sbq.push_back('{64'h0, 2'b00});
    issue(1'b1, 40'h10, 64'h1234);
    l_ack = 1'b1;
    @(negedge clk);
    chk("st_rqtype", 64'(t_rqtype), 64'd1);
    chk("st_data", t_data, 64'h1234);
    chk("st_val", 64'(t_val), 64'd1);
    cyc();
    l_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("st_wait_noresp", 64'(core_resp_val), 64'd0);
      cyc();
    end
    respond(4'b0100, 64'hFFFF, 64'hEEEE, 2'b00);
    cyc();
    chk("st_nresp", 64'(nresp), 64'd2);

    // invalidation in WAIT is acked and dropped
    sbq.push_back('{64'hA5A5, 2'b01});
    issue(1'b0, 40'h20, 64'h0);
    ack_now();
    respond(4'b0011, 64'h1, 64'h2, 2'b00);
    @(negedge clk);
    chk("inv_ack_pulse", 64'(t_req_ack), 64'd0);
    chk("inv_noresp", 64'(core_resp_val), 64'd0);
    chk("inv_still_busy", 64'(core_req_rdy), 64'd0);
    cyc();
    respond(4'b0000, 64'hA5A5, 64'hBAD, 2'b01);
    cyc();
    chk("inv_nresp", 64'(nresp), 64'd3);

    // response backpressure for 4 cycles
    sbq.push_back('{64'h77, 2'b00});
    core_resp_rdy = 1'b0;
    issue(1'b0, 40'h8, 64'h0);
    ack_now();
    respond(4'b0000, 64'h66, 64'h77, 2'b00);
    repeat (4) begin
      @(negedge clk);
      chk("bp_val", 64'(core_resp_val), 64'd1);
      chk("bp_rdata", core_resp_rdata, 64'h77);
      chk("bp_rdy", 64'(core_req_rdy), 64'd0);
      cyc();
    end
    core_resp_rdy = 1'b1;
    cyc();
    chk("bp_nresp", 64'(nresp), 64'd4);

    // reset while waiting, late response dropped
    issue(1'b0, 40'h8, 64'h0);
    ack_now();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_l15_val", 64'(t_val), 64'd0);
    chk("mid_rst_resp", 64'(core_resp_val), 64'd0);
    chk("mid_rst_rdata", core_resp_rdata, 64'd0);
    chk("mid_rst_err", 64'(core_resp_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    respond(4'b0000, 64'h1, 64'h2, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("late_noresp", 64'(core_resp_val), 64'd0);
      cyc();
    end
    chk("late_rdy", 64'(core_req_rdy), 64'd1);

`ifdef L15_TRANSDUCER_TIMEOUT_EN
    // no response: timeout after 16 cycles in REQ/WAIT
    sbq.push_back('{64'h0, 2'b10});
    issue(1'b0, 40'h8, 64'h0);
    l_ack = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      l_ack = 1'b0;
      if (core_resp_val) begin
        n = k;
        break;
      end
    end
    chk("to_cycles", 64'(n), 64'd16);
    chk("to_l15_val", 64'(t_val), 64'd0);
    cyc();
    respond(4'b0000, 64'h5, 64'h6, 2'b00);
    @(negedge clk);
    chk("to_late_noresp", 64'(core_resp_val), 64'd0);
    cyc();
`else
    // no response: waits indefinitely
    issue(1'b0, 40'h8, 64'h0);
    ack_now();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (core_resp_val) n++;
      cyc();
    end
    chk("nto_noresp", 64'(n), 64'd0);
    sbq.push_back('{64'h99, 2'b00});
    respond(4'b0000, 64'h1, 64'h99, 2'b00);
    cyc();
`endif
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("nresp_total", 64'(nresp), 64'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l15_simple_transducer.md
L15_SIMPLE_TRANSDUCER -- requirements
Module: l15_simple_transducer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles allowed from request acceptance to response before timeout (timeout build only).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port core_req_val  in  1  core request valid.
REQ-005 SHALL have port core_req_rdy  out  1  core request accepted when high with core_req_val.
REQ-006 SHALL have port core_req_rw  in  1  1=store, 0=load.
REQ-007 SHALL have port core_req_addr  in  40  physical byte address.
REQ-008 SHALL have port core_req_size  in  3  L1.5 size encoding.
REQ-009 SHALL have port core_req_nc  in  1  noncacheable.
REQ-010 SHALL have port core_req_wdata  in  64  store data.
REQ-011 SHALL have port core_resp_val  out  1  response valid.
REQ-012 SHALL have port core_resp_rdy  in  1  core accepts response.
REQ-013 SHALL have port core_resp_rdata  out  64  load data.
REQ-014 SHALL have port core_resp_err  out  2  {timeout, l2 error}.
REQ-015 SHALL have L1.5-facing ports transducer_l15_{val,rqtype[4:0],nc,size[2:0],address[39:0],data[63:0],data_next_entry[63:0],threadid,amo_op,prefetch,invalidate_cacheline,blockstore,blockinitstore,l1rplway[1:0],csm_data,req_ack} out, and l15_transducer_{ack,header_ack,val,returntype[3:0],error[1:0],data_0[63:0],data_1[63:0]} in, widths per L1.5 header macros.

Function
REQ-016 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
REQ-017 IDLE: core_req_rdy=1; on core_req_val capture rw, addr, size, nc, wdata; go REQ next cycle.
REQ-018 REQ: transducer_l15_val=1 with captured fields held stable; rqtype 5'b00000 load / 5'b00001 store; go WAIT on the cycle l15_transducer_ack=1.
REQ-019 SHALL tie threadid, amo_op, prefetch, invalidate_cacheline, blockstore, blockinitstore, l1rplway, csm_data and data_next_entry to 0.
REQ-020 WAIT: expected response is returntype 4'b0000 (LOAD_RET) for loads, 4'b0100 (ST_ACK) for stores; on match capture data and error, go RESP.
REQ-021 Load rdata SHALL be l15_transducer_data_1 if addr[3]=1, else data_0; stores return rdata=0.
REQ-022 transducer_l15_req_ack SHALL equal l15_transducer_val combinationally in every state, including non-matching (invalidation/unsolicited) responses, which are otherwise dropped.
REQ-023 RESP: core_resp_val=1, outputs stable; go IDLE on core_resp_rdy; core_req_rdy=0 in REQ, WAIT and RESP (one outstanding request).
REQ-024 A matching response arriving in REQ (same cycle as ack) SHALL be consumed as if in WAIT, going directly to RESP.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, transducer_l15_val=0, core_resp_val=0, core_resp_rdata=0, core_resp_err=0, all captured registers 0; an in-flight request is abandoned and its late response is acked and dropped.
REQ-026 core_req_rdy SHALL be 1 from the first cycle after reset deassertion.

Configuration
REQ-027 With L15_TRANSDUCER_TIMEOUT_EN defined: counter clears on entry to REQ, increments each cycle in REQ/WAIT, saturates; on reaching TIMEOUT_CYCLES go RESP with core_resp_err[1]=1, rdata=0, transducer_l15_val deasserted; the late response is later acked and dropped.
REQ-028 Without L15_TRANSDUCER_TIMEOUT_EN: no counter, core_resp_err[1] constant 0, WAIT indefinitely.

Verification
REQ-029 Load addr 0x00_8000_0008, L1.5 ack after 3 cycles, LOAD_RET data_1=0xDEAD_BEEF_0000_0001 -> core_resp_rdata=0xDEAD_BEEF_0000_0001, err=0.
REQ-030 Store wdata 0x1234, ack same cycle as val, ST_ACK 5 cycles later -> rqtype=5'b00001, transducer_l15_data=0x1234 stable until ack, one core_resp_val.
REQ-031 Invalidation (returntype 4'b0011) during WAIT -> req_ack pulses 1 cycle, FSM stays WAIT, no core response.
REQ-032 core_resp_rdy low 4 cycles -> resp_val and rdata held, core_req_rdy=0 throughout.
REQ-033 rst_n low while in WAIT, response arrives after release -> outputs at reset values, response acked, no core_resp_val.
REQ-034 Timeout build, TIMEOUT_CYCLES=16, no response -> core_resp_val with err=2'b10 after 16 cycles.
